// File: rtl/spart_frame_tx_if.sv
// rtl/spart_frame_tx_if.sv - Requester handshakes and SPART FIFO write port for spart_frame_tx
interface spart_frame_tx_if #(
  parameter int N_NIB = 15
);
  logic               req0;
  logic [4*N_NIB-1:0] payload0;
  logic               ack0;
  logic               req1;
  logic [4*N_NIB-1:0] payload1;
  logic               ack1;
  logic               busy;
  logic               full;
  logic               send;
  logic [7:0]         fifo_data;

  modport master (
    input  req0, payload0, req1, payload1, full,
    output ack0, ack1, busy, send, fifo_data
  );

  modport slave (
    output req0, payload0, req1, payload1, full,
    input  ack0, ack1, busy, send, fifo_data
  );
endinterface

// File: rtl/spart_frame_tx.sv
// rtl/spart_frame_tx.sv - Round-robin frame scheduler writing nibble-tagged bytes into the SPART TX FIFO
module spart_frame_tx #(
  parameter int         N_NIB     = 15,
  parameter logic [7:0] TERM_BYTE = 8'hF0
) (
  input logic              clk,
  input logic              rst,
  spart_frame_tx_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] TERM = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [3:0] LAST_IDX = 4'(N_NIB - 1);

  logic [1:0]         state;
  logic [3:0]         idx;
  logic [4*N_NIB-1:0] frame;
  logic               grant;
  logic               last_grant;
  logic               ack0_q;
  logic               ack1_q;
  logic               pick;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    pick = 1'b0;
    if (bus.req0 && bus.req1) pick = ~last_grant;
    else if (bus.req1)        pick = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 4'd0;
      frame      <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            frame <= pick ? bus.payload1 : bus.payload0;
            idx   <= 4'd0;
            grant <= pick;
            state <= SEND;
          end
        end
        SEND: begin
          // Shifting keeps the nibble for the current tag in the top slot.
          if (!bus.full) begin
            frame <= frame << 4;
            idx   <= idx + 4'd1;
            if (idx == LAST_IDX) state <= TERM;
          end
        end
        TERM: begin
          if (!bus.full) begin
            ack0_q <= ~grant;
            ack1_q <= grant;
            state  <= DONE;
          end
        end
        DONE: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.send      = 1'b0;
    bus.fifo_data = 8'h00;
    case (state)
      SEND: begin
        bus.send      = ~bus.full;
        bus.fifo_data = {idx, frame[4*N_NIB-1 -: 4]};
      end
      TERM: begin
        bus.send      = ~bus.full;
        bus.fifo_data = TERM_BYTE;
      end
      default: ;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.ack0 = ack0_q;
  assign bus.ack1 = ack1_q;
endmodule

// File: doc/spart_frame_tx.md
Name: spart_frame_tx

Overview:
- Transmit-side frame scheduler for the SPART. It shares the SPART transmit FIFO (write port: send / data_in / full) between two requesters.
- For each granted frame it serialises the payload into nibble-tagged bytes {index[3:0], nibble[3:0]}, then emits a terminator byte with tag 4'hF. The far-end SPART receive path stores each byte by tag and raises RCV on tag 4'hF.
- Grants are round-robin. There is no gap between frames beyond the fixed grant and ack cycles.

Parameters:
- N_NIB, 15, data nibbles per frame (legal 1..15); tags sent are 0..N_NIB-1.
- TERM_BYTE, 8'hF0, terminator byte; bits [7:4] must be 4'hF.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req0  input  1  requester 0 frame request; held high until ack0
- payload0  input  4*N_NIB  requester 0 frame data; nibble i = payload0[4*(N_NIB-1-i)+:4], so the MSB nibble is tag 0
- ack0  output  1  one-cycle pulse: requester 0 frame fully written to FIFO
- req1  input  1  requester 1 frame request
- payload1  input  4*N_NIB  requester 1 frame data, same layout
- ack1  output  1  one-cycle pulse for requester 1
- busy  output  1  high in any state other than IDLE
- full  input  1  SPART FIFO full
- send  output  1  SPART FIFO write enable
- fifo_data  output  8  SPART FIFO write data

Behaviour:
- Reset state: state=IDLE, idx=0, last_grant=1 (requester 0 wins the first tie).
- Reset output values: send=0, fifo_data=8'h00, ack0=0, ack1=0, busy=0.

State machine (IDLE, SEND, TERM, DONE):
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the one that is not last_grant.
  - On grant: latch the granted payload into the frame register, set idx=0, record the grant, go to SEND.
  - Payload is sampled only on the grant edge; later payload changes are ignored.
- SEND:
  - fifo_data = {idx, frame nibble idx}, combinational from registers.
  - send = ~full (combinational).
  - On an edge with ~full: idx++. If idx == N_NIB-1, go to TERM.
  - On an edge with full: hold; no write.
- TERM:
  - fifo_data = TERM_BYTE; send = ~full.
  - On an edge with ~full: go to DONE.
- DONE:
  - Pulse ack of the granted requester for exactly 1 cycle (registered, asserted during DONE).
  - last_grant <= granted requester; go to IDLE.

General rules:
- send is 0 in IDLE and DONE. fifo_data outside SEND/TERM is 8'h00.
- Exactly one FIFO write occurs per edge with send=1. No byte is ever written while full=1.
- Latency: grant edge to first send = 1 cycle. A frame with no backpressure takes N_NIB+3 cycles from grant to re-entry into IDLE (18 cycles for the default).
- Round-robin fairness: with both requests held continuously, grants alternate 0,1,0,1...
- Requester rules:
  - A requester must keep req high until its ack. Dropping req mid-frame does not abort the frame; ack is still issued.
  - req still high on the cycle after ack is treated as a new request.
- rst mid-frame: state returns to IDLE next edge and send=0 from that cycle. No ack is issued. A partial frame with no terminator remains in the FIFO; the far end does not raise RCV for it.
- The SPART clock domain is shared, so no synchroniser is required.

Test Plan:
- Single frame: rst 2 cycles; req0=1, payload0=60'h123456789ABCDEF, full=0. Required FIFO writes on consecutive cycles: 8'h01, 8'h12, 8'h23 ... 8'hEF, then 8'hF0. ack0 pulses 17 cycles after grant. busy=1 throughout. ack1 never asserts.
- Backpressure: same frame; force full=1 for 5 cycles starting at the 4th byte. Required: send=0 while full, no duplicate or skipped tag, stream resumes with 8'h34. Total write count is 16.
- Arbitration: req0 and req1 both raised the same cycle after reset, payloads all-5s and all-A's. Required: frame 0 first (bytes x5), then frame 1 (bytes xA), alternating for 4 frames. Ack order 0,1,0,1.
- Request drop: raise req1, deassert it 3 cycles after grant. Required: all 16 bytes are still written and ack1 pulses once.
- Reset mid-frame: assert rst after the 7th byte. Required: send=0 the following cycle, no ack, busy=0. A new req0 afterwards restarts at tag 0.
- Idle hygiene: no requests for 50 cycles with full toggling. Required: send=0, fifo_data=8'h00, busy=0 throughout.
